// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Bundle of fetch-side inputs, writeback port, flush and the
//               ID/EX register outputs of the RV32i decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC_Plus_4_D;
    logic        Flush_E;
    logic        Reg_Write_W;
    logic [4:0]  RD_W;
    logic [31:0] Result_W;

    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RS1_E;
    logic [4:0]  RS2_E;
    logic [4:0]  RD_E;
    logic [31:0] PC_E;
    logic [31:0] PC_Plus_4_E;
    logic [2:0]  Funct3_E;
    logic [3:0]  ALU_Control_E;
    logic        ALU_Src_A_E;
    logic        ALU_Src_B_E;
    logic [1:0]  Result_Src_E;
    logic        Reg_Write_E;
    logic        Mem_Write_E;
    logic        Branch_E;
    logic        Jump_E;
    logic        Valid_E;
    logic        Illegal_E;

    modport master (
        output Instr_D, PC_D, PC_Plus_4_D, Flush_E, Reg_Write_W, RD_W, Result_W,
        input  RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PC_E, PC_Plus_4_E,
               Funct3_E, ALU_Control_E, ALU_Src_A_E, ALU_Src_B_E, Result_Src_E,
               Reg_Write_E, Mem_Write_E, Branch_E, Jump_E, Valid_E, Illegal_E
    );

    modport slave (
        input  Instr_D, PC_D, PC_Plus_4_D, Flush_E, Reg_Write_W, RD_W, Result_W,
        output RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PC_E, PC_Plus_4_E,
               Funct3_E, ALU_Control_E, ALU_Src_A_E, ALU_Src_B_E, Result_Src_E,
               Reg_Write_E, Mem_Write_E, Branch_E, Jump_E, Valid_E, Illegal_E
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32i decode stage: control decode, register file with
//               write-through bypass, immediate generation, ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    decode_stage_if.slave bus
);
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_IALU  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BRAN  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    logic [31:0] r_regs [32];

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_wb_en;
    logic [31:0] w_rd1, w_rd2;
    logic [3:0]  w_alu_base;
    logic [3:0]  w_alu;
    logic        w_src_a, w_src_b;
    logic [1:0]  w_res_src;
    logic        w_reg_write, w_mem_write, w_branch, w_jump, w_illegal;
    logic [31:0] w_imm;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

    assign w_instr  = bus.Instr_D;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_alt    = w_instr[30];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];

    // Same-cycle writeback is forwarded so W and D may overlap without a stall
    assign w_wb_en = bus.Reg_Write_W && (bus.RD_W != 5'd0);
    assign w_rd1   = (w_rs1 == 5'd0) ? 32'h0 :
                     (w_wb_en && bus.RD_W == w_rs1) ? bus.Result_W : r_regs[w_rs1];
    assign w_rd2   = (w_rs2 == 5'd0) ? 32'h0 :
                     (w_wb_en && bus.RD_W == w_rs2) ? bus.Result_W : r_regs[w_rs2];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'h0};

    // Shared funct3 table; only SRA/SRAI picks up funct7[5] here, SUB is R-type only
    always_comb begin
        w_alu_base = c_ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_base = c_ALU_ADD;
            3'b001:  w_alu_base = c_ALU_SLL;
            3'b010:  w_alu_base = c_ALU_SLT;
            3'b011:  w_alu_base = c_ALU_SLTU;
            3'b100:  w_alu_base = c_ALU_XOR;
            3'b101:  w_alu_base = w_alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  w_alu_base = c_ALU_OR;
            default: w_alu_base = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_alu       = c_ALU_ADD;
        w_src_a     = 1'b0;
        w_src_b     = 1'b0;
        w_res_src   = 2'b00;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        w_imm       = 32'h0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_alu       = (w_funct3 == 3'b000 && w_alt) ? c_ALU_SUB : w_alu_base;
                w_reg_write = 1'b1;
            end
            c_OP_IALU: begin
                w_alu       = w_alu_base;
                w_src_b     = 1'b1;
                w_reg_write = 1'b1;
                w_imm       = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ?
                              {27'h0, w_instr[24:20]} : w_imm_i;
            end
            c_OP_LOAD: begin
                w_src_b     = 1'b1;
                w_res_src   = 2'b01;
                w_reg_write = 1'b1;
                w_imm       = w_imm_i;
            end
            c_OP_STORE: begin
                w_src_b     = 1'b1;
                w_mem_write = 1'b1;
                w_imm       = w_imm_s;
            end
            c_OP_BRAN: begin
                w_alu    = c_ALU_SUB;
                w_branch = 1'b1;
                w_imm    = w_imm_b;
            end
            c_OP_JAL: begin
                w_jump      = 1'b1;
                w_src_a     = 1'b1;
                w_src_b     = 1'b1;
                w_res_src   = 2'b10;
                w_reg_write = 1'b1;
                w_imm       = w_imm_j;
            end
            c_OP_JALR: begin
                w_jump      = 1'b1;
                w_src_b     = 1'b1;
                w_res_src   = 2'b10;
                w_reg_write = 1'b1;
                w_imm       = w_imm_i;
            end
            c_OP_LUI: begin
                w_alu       = c_ALU_PASSB;
                w_src_b     = 1'b1;
                w_reg_write = 1'b1;
                w_imm       = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_src_a     = 1'b1;
                w_src_b     = 1'b1;
                w_reg_write = 1'b1;
                w_imm       = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else if (w_wb_en) begin
            r_regs[bus.RD_W] <= bus.Result_W;
        end
    end

    // A bubble reuses the reset image of the ID/EX register
    always_ff @(posedge CLK) begin
        if (RST || bus.Flush_E) begin
            bus.RD1_E         <= 32'h0;
            bus.RD2_E         <= 32'h0;
            bus.Imm_Ext_E     <= 32'h0;
            bus.RS1_E         <= 5'd0;
            bus.RS2_E         <= 5'd0;
            bus.RD_E          <= 5'd0;
            bus.PC_E          <= RESET_PC;
            bus.PC_Plus_4_E   <= RESET_PC + 32'd4;
            bus.Funct3_E      <= 3'd0;
            bus.ALU_Control_E <= c_ALU_ADD;
            bus.ALU_Src_A_E   <= 1'b0;
            bus.ALU_Src_B_E   <= 1'b0;
            bus.Result_Src_E  <= 2'b00;
            bus.Reg_Write_E   <= 1'b0;
            bus.Mem_Write_E   <= 1'b0;
            bus.Branch_E      <= 1'b0;
            bus.Jump_E        <= 1'b0;
            bus.Valid_E       <= 1'b0;
            bus.Illegal_E     <= 1'b0;
        end else begin
            bus.RD1_E         <= w_rd1;
            bus.RD2_E         <= w_rd2;
            bus.Imm_Ext_E     <= w_imm;
            bus.RS1_E         <= w_rs1;
            bus.RS2_E         <= w_rs2;
            bus.RD_E          <= w_rd;
            bus.PC_E          <= bus.PC_D;
            bus.PC_Plus_4_E   <= bus.PC_Plus_4_D;
            bus.Funct3_E      <= w_funct3;
            bus.ALU_Control_E <= w_alu;
            bus.ALU_Src_A_E   <= w_src_a;
            bus.ALU_Src_B_E   <= w_src_b;
            bus.Result_Src_E  <= w_res_src;
            bus.Reg_Write_E   <= w_reg_write && (w_rd != 5'd0);
            bus.Mem_Write_E   <= w_mem_write;
            bus.Branch_E      <= w_branch;
            bus.Jump_E        <= w_jump;
            bus.Valid_E       <= 1'b1;
            bus.Illegal_E     <= w_illegal;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed plus random bench for decode_stage against a
//               behavioural register-file / decode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        sa, sb;
        logic [1:0]  rsrc;
        logic        rw, mw, br, jp, v, ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mregs [32];
    exp_t exp_v, got_v;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage #(.RESET_PC(RESET_PC)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wres);
        if (idx == 0) return 32'h0;
        if (we && wrd == idx) return wres;
        return mregs[idx];
    endfunction

    function automatic logic [3:0] alu_r(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, pc, pc4, input logic fl, r,
                                   input logic we, input logic [4:0] wrd, input logic [31:0] wres);
        exp_t e;
        int si, ss, sb, sj;
        logic rw;
        e = '0;
        e.pc = RESET_PC;
        e.pc4 = RESET_PC + 32'd4;
        if (r || fl) return e;
        si = $signed(ins[31:20]);
        ss = $signed({ins[31:25], ins[11:7]});
        sb = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        sj = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rd1 = mread(e.rs1, we, wrd, wres);
        e.rd2 = mread(e.rs2, we, wrd, wres);
        e.pc = pc; e.pc4 = pc4; e.f3 = ins[14:12]; e.v = 1'b1;
        rw = 1'b0;
        case (ins[6:0])
            7'b0110011: begin e.alu = alu_r(e.f3, ins[30]); rw = 1; end
            7'b0010011: begin
                e.alu = (e.f3 == 0) ? 4'd0 : alu_r(e.f3, ins[30]);
                e.sb = 1; rw = 1;
                e.imm = (e.f3 == 1 || e.f3 == 5) ? 32'(ins[24:20]) : 32'(si);
            end
            7'b0000011: begin e.sb = 1; e.rsrc = 2'd1; rw = 1; e.imm = 32'(si); end
            7'b0100011: begin e.sb = 1; e.mw = 1; e.imm = 32'(ss); end
            7'b1100011: begin e.alu = 4'd1; e.br = 1; e.imm = 32'(sb); end
            7'b1101111: begin e.jp = 1; e.sa = 1; e.sb = 1; e.rsrc = 2'd2; rw = 1; e.imm = 32'(sj); end
            7'b1100111: begin e.jp = 1; e.sb = 1; e.rsrc = 2'd2; rw = 1; e.imm = 32'(si); end
            7'b0110111: begin e.alu = 4'd10; e.sb = 1; rw = 1; e.imm = {ins[31:12], 12'h0}; end
            7'b0010111: begin e.sa = 1; e.sb = 1; rw = 1; e.imm = {ins[31:12], 12'h0}; end
            default:    e.ill = 1'b1;
        endcase
        e.rw = rw && (e.rd != 0);
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.rd1 = bus.RD1_E; o.rd2 = bus.RD2_E; o.imm = bus.Imm_Ext_E;
        o.rs1 = bus.RS1_E; o.rs2 = bus.RS2_E; o.rd = bus.RD_E;
        o.pc = bus.PC_E; o.pc4 = bus.PC_Plus_4_E; o.f3 = bus.Funct3_E;
        o.alu = bus.ALU_Control_E; o.sa = bus.ALU_Src_A_E; o.sb = bus.ALU_Src_B_E;
        o.rsrc = bus.Result_Src_E; o.rw = bus.Reg_Write_E; o.mw = bus.Mem_Write_E;
        o.br = bus.Branch_E; o.jp = bus.Jump_E; o.v = bus.Valid_E; o.ill = bus.Illegal_E;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic step(input logic [31:0] ins, pc, input logic fl, r, we,
                        input logic [4:0] wrd, input logic [31:0] wres);
        rst = r;
        bus.Instr_D = ins; bus.PC_D = pc; bus.PC_Plus_4_D = pc + 32'd4;
        bus.Flush_E = fl; bus.Reg_Write_W = we; bus.RD_W = wrd; bus.Result_W = wres;
        exp_v = model(ins, pc, pc + 32'd4, fl, r, we, wrd, wres);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else if (we && wrd != 0) begin
            mregs[wrd] = wres;
        end
        #1;
        got_v = observe();
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL step ins=%h: got %h expected %h", ins, got_v, exp_v);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81b3;

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] ins;
        logic [4:0]  wrd;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        step(NOP, 32'h0, 0, 1, 0, 5'd0, 32'h0);
        chk("reset_pc", bus.PC_E, RESET_PC);
        chk("reset_pc4", bus.PC_Plus_4_E, RESET_PC + 32'd4);
        chk("reset_valid", 32'(bus.Valid_E), 32'd0);

        step(32'h0020_0093, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        chk("addi_rd", 32'(bus.RD_E), 32'd1);
        chk("addi_rs1", 32'(bus.RS1_E), 32'd0);
        chk("addi_imm", bus.Imm_Ext_E, 32'd2);
        chk("addi_srcb", 32'(bus.ALU_Src_B_E), 32'd1);
        chk("addi_alu", 32'(bus.ALU_Control_E), 32'd0);
        chk("addi_rw", 32'(bus.Reg_Write_E), 32'd1);
        chk("addi_valid", 32'(bus.Valid_E), 32'd1);
        chk("addi_rd1", bus.RD1_E, 32'd0);

        step(NOP, 32'h4, 0, 0, 1, 5'd2, 32'd7);
        step(ADD, 32'h8, 0, 0, 1, 5'd1, 32'd5);
        chk("add_bypass_rd1", bus.RD1_E, 32'd5);
        chk("add_rd2", bus.RD2_E, 32'd7);
        chk("add_rd", 32'(bus.RD_E), 32'd3);

        step(32'h0000_0033, 32'hC, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
        chk("x0_bypass", bus.RD1_E, 32'd0);
        step(32'h0000_0033, 32'h10, 0, 0, 0, 5'd0, 32'h0);
        chk("x0_read", bus.RD1_E, 32'd0);

        step(32'hFE00_0CE3, 32'h14, 0, 0, 0, 5'd0, 32'h0);
        chk("beq_imm", bus.Imm_Ext_E, 32'hFFFF_FFF8);
        chk("beq_branch", 32'(bus.Branch_E), 32'd1);
        chk("beq_alu", 32'(bus.ALU_Control_E), 32'd1);
        chk("beq_rw", 32'(bus.Reg_Write_E), 32'd0);

        step(32'h0000_006F, 32'd12, 0, 0, 0, 5'd0, 32'h0);
        chk("jal_jump", 32'(bus.Jump_E), 32'd1);
        chk("jal_rsrc", 32'(bus.Result_Src_E), 32'd2);
        chk("jal_imm", bus.Imm_Ext_E, 32'd0);
        chk("jal_rw", 32'(bus.Reg_Write_E), 32'd0);
        chk("jal_pc4", bus.PC_Plus_4_E, 32'd16);

        step(ADD, 32'h18, 1, 0, 1, 5'd1, 32'h55);
        chk("flush_valid", 32'(bus.Valid_E), 32'd0);
        chk("flush_rw", 32'(bus.Reg_Write_E), 32'd0);
        step(ADD, 32'h1C, 0, 0, 0, 5'd0, 32'h0);
        chk("flush_wb_kept", bus.RD1_E, 32'h55);

        step(ADD, 32'h20, 0, 1, 1, 5'd1, 32'h77);
        chk("rst_valid", 32'(bus.Valid_E), 32'd0);
        step(ADD, 32'h24, 0, 0, 0, 5'd0, 32'h0);
        chk("rst_clears_x1", bus.RD1_E, 32'd0);

        step(32'hFFFF_FFFF, 32'h28, 0, 0, 0, 5'd0, 32'h0);
        chk("ill_flag", 32'(bus.Illegal_E), 32'd1);
        chk("ill_rw", 32'(bus.Reg_Write_E), 32'd0);

        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            wrd = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom);
            step(ins, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) == 0), 1'($urandom), wrd, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the RV32i core; consumes Instr_D, PC_D and PC_Plus_4_D from the fetch stage.
- Decodes the instruction, reads the 32x32 register file (which it owns), and builds the sign-extended immediate.
- Registers all results into the ID/EX pipeline register (_E outputs) for the execute stage.
- Accepts the writeback port from W and a flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0: value loaded into PC_E and PC_Plus_4_E on reset or bubble.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- Instr_D  in  32  instruction from fetch.
- PC_D  in  32  PC of Instr_D.
- PC_Plus_4_D  in  32  PC_D+4.
- Flush_E  in  1  load a bubble into ID/EX this cycle.
- Reg_Write_W  in  1  writeback enable.
- RD_W  in  5  writeback destination.
- Result_W  in  32  writeback data.
- RD1_E, RD2_E  out  32  register operands.
- Imm_Ext_E  out  32  sign-extended immediate.
- RS1_E, RS2_E, RD_E  out  5  register indices, for forwarding.
- PC_E, PC_Plus_4_E  out  32  passthrough.
- Funct3_E  out  3  instr[14:12], used for branch and load/store width.
- ALU_Control_E  out  4  operation code:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- ALU_Src_A_E  out  1  1 = PC operand (AUIPC/JAL).
- ALU_Src_B_E  out  1  1 = immediate operand.
- Result_Src_E  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- Reg_Write_E, Mem_Write_E, Branch_E, Jump_E  out  1  control signals.
- Valid_E, Illegal_E  out  1  real instruction present; illegal opcode seen.

Behaviour:
- Reset (RST=1 at posedge):
  - Every _E output becomes 0, except PC_E=RESET_PC and PC_Plus_4_E=RESET_PC+4.
  - All 32 registers are cleared to 0.
  - RST has priority over every other input, including a writeback in the same cycle.
- Register file:
  - Write at posedge when Reg_Write_W=1 and RD_W!=0; writes to x0 are ignored.
  - Reads are combinational; x0 always reads 0.
  - Write-through bypass: if Reg_Write_W=1, RD_W!=0 and RD_W equals the read index, the read returns Result_W in that same cycle.
- Latency:
  - Exactly one cycle from D inputs to _E outputs; no internal stall.
  - A stall is realised by the hazard unit asserting Flush_E while fetch holds D.
- Flush_E=1 (no RST) loads a bubble: Valid_E, Reg_Write_E, Mem_Write_E, Branch_E, Jump_E and Illegal_E all 0. Other fields are don't-care, but drive them to 0.
- Decode by opcode (instr[6:0]):
  - 0110011 R-type:
    - ALU op from funct3 plus funct7[5] (SUB, SRA).
    - Reg_Write=1.
  - 0010011 I-ALU:
    - ALU_Src_B=1, Reg_Write=1.
    - funct7[5] is honoured only for SRAI; ADDI never produces SUB.
    - Shift immediate is instr[24:20], zero-extended.
  - 0000011 load: ADD, ALU_Src_B=1, Result_Src=01, Reg_Write=1.
  - 0100011 store: ADD, ALU_Src_B=1, Mem_Write=1, Reg_Write=0.
  - 1100011 branch: SUB, Branch=1.
  - 1101111 JAL: Jump=1, ALU_Src_A=1, ALU_Src_B=1, ADD, Result_Src=10, Reg_Write=1.
  - 1100111 JALR: Jump=1, ALU_Src_B=1, ADD, Result_Src=10, Reg_Write=1.
  - 0110111 LUI: PASSB, ALU_Src_B=1, Reg_Write=1.
  - 0010111 AUIPC: ADD, ALU_Src_A=1, ALU_Src_B=1, Reg_Write=1.
  - Any other opcode: bubble controls with Illegal_E=1 and Valid_E=1.
- Immediate formats, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'h0}.
  - R-type: Imm_Ext = 0.
- Index fields: RS1/RS2/RD are taken from instr fields regardless of format. Reg_Write=0 whenever RD=0 (NOP-safe).
- Simultaneous events:
  - Flush_E together with a writeback: the bubble loads and the register write still occurs.
  - RST together with a writeback: reset wins.

Test Plan:
- Reset, then Instr_D=32'h00200093 (ADDI x1,x0,2) -> next cycle: RD_E=1, RS1_E=0, Imm_Ext_E=2, ALU_Src_B_E=1, ALU_Control_E=0, Reg_Write_E=1, Valid_E=1, RD1_E=0.
- Writeback Reg_Write_W=1, RD_W=1, Result_W=5 in the same cycle as Instr_D=32'h002081b3 (ADD x3,x1,x2) with x2 already =7 -> RD1_E=5, RD2_E=7, RD_E=3.
- Write RD_W=0, Result_W=32'hDEADBEEF, then read x0 -> RD1_E=0.
- Instr_D=32'hFE000CE3 (BEQ x0,x0,-8) -> Imm_Ext_E=32'hFFFFFFF8, Branch_E=1, ALU_Control_E=1, Reg_Write_E=0.
- Instr_D=32'h0000006f (JAL x0,0) with PC_D=12 -> Jump_E=1, Result_Src_E=2, Imm_Ext_E=0, Reg_Write_E=0 (RD=0), PC_Plus_4_E=16.
- Flush and reset:
  - Flush_E=1 during a valid ADD -> Valid_E=0, Reg_Write_E=0.
  - RST pulse mid-stream -> all outputs reset; previously written x1 reads 0.
  - Instr_D=32'hFFFFFFFF -> Illegal_E=1, Reg_Write_E=0.
